// File: rtl/stg1if_pkg.sv
// Shared sizes and helpers for the fetch stage (stg1if) and its output FIFO.
package stg1if_pkg;
   localparam int ADDR_W_DEF  = 24;
   localparam int INSTR_W_DEF = 24;
   localparam int CNT_W_DEF   = 16;
   localparam int FIFO_DEPTH  = 2;

   typedef logic [1:0] fifo_cnt_t;

   // True when buffered + in-flight words, after this cycle's pop, leave room for one more.
   function automatic logic has_room(input fifo_cnt_t count, input logic inflight, input logic pop);
      return (int'(count) + int'(inflight) - int'(pop)) <= (FIFO_DEPTH - 1);
   endfunction
endpackage

// File: rtl/stg1if_fifo2.sv
// Two-entry FIFO of fetched {pc, instr} words; clear empties it and wins over push/pop.
module if_fifo2
   import stg1if_pkg::*;
#(
   parameter int W = 48
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output fifo_cnt_t    count
);
   logic [W-1:0] mem_reg [FIFO_DEPTH];
   logic         wr_ptr_reg;
   logic         rd_ptr_reg;
   fifo_cnt_t    count_reg;
   fifo_cnt_t    count_next;

   always_comb begin
      count_next = count_reg;
      if (push && !pop)
         count_next = count_reg + 2'd1;
      else if (pop && !push)
         count_next = count_reg - 2'd1;
   end

   // Entries are reset so the head reads as zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem_reg[i] <= '0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= '0;
      end else if (clear) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            mem_reg[wr_ptr_reg] <= din;
            wr_ptr_reg          <= ~wr_ptr_reg;
         end
         if (pop)
            rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_next;
      end
   end

   assign dout  = mem_reg[rd_ptr_reg];
   assign count = count_reg;
endmodule

// File: rtl/stg1if.sv
// Instruction fetch stage: issues one-cycle-latency imem reads and buffers returns for decode.
module stg1if
   import stg1if_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               iw_clk,
   input  logic               iw_rst_n,
   input  logic [ADDR_W-1:0]  iw_pc,
   input  logic               iw_pc_valid,
   output logic               ow_pc_ready,
   output logic               ow_imem_en,
   output logic [ADDR_W-1:0]  ow_imem_addr,
   input  logic [INSTR_W-1:0] iw_imem_data,
   output logic [ADDR_W-1:0]  ow_ifid_pc,
   output logic [INSTR_W-1:0] ow_ifid_instr,
   output logic               ow_ifid_valid,
   input  logic               iw_stall,
   input  logic               iw_flush,
   output logic [CNT_W-1:0]   ow_bubble_cnt
);
   logic                      accept;
   logic                      pop;
   logic                      push;
   logic                      inflight_reg;
   logic [ADDR_W-1:0]         inflight_pc_reg;
   logic [ADDR_W-1:0]         imem_addr_reg;
   logic [CNT_W-1:0]          bubble_cnt_reg;
   fifo_cnt_t                 fifo_count;
   logic [ADDR_W+INSTR_W-1:0] fifo_dout;

   assign ow_ifid_valid = (fifo_count != '0);
   assign pop           = ow_ifid_valid & ~iw_stall;
   // A flush kills the word returning this cycle simply by not pushing it.
   assign push          = inflight_reg & ~iw_flush;
   assign ow_pc_ready   = ~iw_flush & has_room(fifo_count, inflight_reg, pop);
   assign accept        = iw_pc_valid & ow_pc_ready;
   assign ow_imem_en    = accept;
   assign ow_imem_addr  = accept ? iw_pc : imem_addr_reg;

   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= '0;
         imem_addr_reg   <= '0;
      end else begin
         inflight_reg <= accept;
         if (accept) begin
            inflight_pc_reg <= iw_pc;
            imem_addr_reg   <= iw_pc;
         end
      end
   end

   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n)
         bubble_cnt_reg <= '0;
      else if (!ow_ifid_valid && (bubble_cnt_reg != '1))
         bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
   end

   if_fifo2 #(
      .W(ADDR_W + INSTR_W)
   ) u_fifo (
      .clk   (iw_clk),
      .rst_n (iw_rst_n),
      .clear (iw_flush),
      .push  (push),
      .pop   (pop),
      .din   ({inflight_pc_reg, iw_imem_data}),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   assign ow_ifid_pc    = fifo_dout[ADDR_W+INSTR_W-1:INSTR_W];
   assign ow_ifid_instr = fifo_dout[INSTR_W-1:0];
   assign ow_bubble_cnt = bubble_cnt_reg;
endmodule
